i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- 7-bit-address I2C target (slave) for the I2C bus plugin; the counterpart of the plugin's I2C master, used for loopback tests and FPGA-as-peripheral designs.
- Oversamples SCL/SDA on the system clock, detects START/STOP/repeated START, matches its address, ACKs, and handles both transfer directions.
- Write transfers: shifts bytes into `rx_data`. Read transfers: shifts up to 4 bytes out of `tx_data`, MSB byte first.

Parameters:
- `ADDRESS`, 7'h42, 7-bit bus address this target answers to.
- `HOLD`, 4, clk cycles after a detected SCL falling edge before SDA output changes. Range 1..15.

Ports:
- `clk`  input  1  system clock
- `rst`  input  1  synchronous reset, active-high
- `scl`  input  1  I2C clock; never driven, no clock stretching
- `sda`  inout  1  I2C data, open-drain: drives 0 or `z`, never drives 1
- `tx_data`  input  32  read payload; sampled at address-ACK of a read
- `tx_bytes`  input  3  number of valid read bytes, 0..4; sampled with `tx_data`
- `rx_data`  output  32  shift register; each received byte enters at [7:0], older bytes move up
- `rx_byte_valid`  output  1  one-clk pulse per received data byte
- `rx_count`  output  3  data bytes received in the current write, saturating at 7
- `rw`  output  1  R/W bit of the last matched address byte
- `busy`  output  1  high from a matched address ACK until STOP or reset
- `done`  output  1  one-clk pulse on STOP that ends a matched transfer

Behaviour:
- Reset values: `rx_data`=0, `rx_byte_valid`=0, `rx_count`=0, `rw`=0, `busy`=0, `done`=0, SDA released, state IDLE.
- Reset mid-transfer: releases SDA in the same cycle and returns to IDLE. No `done` pulse.
- Input sampling:
  - `scl` and `sda` each pass through a 2-FF synchronizer, plus a third register for edge detection.
  - All bus events are 3 clks behind the pins.
  - SCL rise/fall = synced value changes.
- Bus events:
  - START = synced SDA 1→0 while synced SCL=1.
  - STOP = synced SDA 0→1 while synced SCL=1.
  - START and STOP take priority over bit processing in any state.
- SDA drive rules:
  - SDA changes only `HOLD` clks after an SCL falling edge.
  - SDA data is sampled on SCL rising edges.
- States:
  - IDLE: SDA released. START → ADDR, bit counter=0.
  - ADDR:
    - Shift 8 bits on SCL rises.
    - After the 8th rise: if [7:1]==`ADDRESS`, latch `rw`, then → ADDR_ACK. Otherwise → IGNORE.
  - ADDR_ACK:
    - Pull SDA low for the 9th clock: asserted `HOLD` clks after the 8th fall, released `HOLD` clks after the 9th fall.
    - `busy`=1 from the start of ACK drive.
    - `rw`=0 → WRITE with `rx_count`=0.
    - `rw`=1 → latch `tx_data`/`tx_bytes`, byte index = `tx_bytes`, → READ.
  - WRITE:
    - Shift 8 bits; after the 8th rise: `rx_data` <= {`rx_data`[23:0], byte}, pulse `rx_byte_valid`, increment `rx_count` (saturating at 7).
    - Then → WRITE_ACK.
    - A START or STOP seen mid-byte discards the partial byte with no pulse.
  - WRITE_ACK: drive ACK exactly as in ADDR_ACK (every byte is ACKed), then → WRITE.
  - READ:
    - Drive bits MSB first: bit 7 goes out after the ACK-release fall, each following bit `HOLD` clks after each fall.
    - Byte source: `tx_data`[8*idx-1 -: 8] while idx>0; 8'hFF when idx=0 (i.e. `tx_bytes`=0 or payload exhausted).
    - Decrement idx per byte, floor 0.
    - A 0 bit drives low; a 1 bit releases.
    - Release SDA `HOLD` clks after the 8th fall, then → READ_ACK.
  - READ_ACK:
    - Sample SDA on the 9th rise.
    - 0 (ACK) → READ with the next byte.
    - 1 (NACK) → IGNORE; stays released.
  - IGNORE: SDA released, wait for START (→ ADDR) or STOP (→ IDLE).
- Repeated START while busy:
  - → ADDR. `busy` stays high.
  - Goes low only if the new address mismatches (at the 8th rise).
  - No `done` pulse.
- STOP from any state:
  - → IDLE, SDA released, `busy`=0.
  - `done` pulses only if `busy` was 1.
  - `rx_data` and `rx_count` hold their values until the next matched write's first byte.

Test Plan:
- Write 2 bytes, master address 0x42: START, 0x84 (addr<<1|0), 0xA5, 0x3C, STOP → ACK on all 3 bytes; 2 `rx_byte_valid` pulses; `rx_data`=0x0000A53C; `rx_count`=2; `rw`=0; one `done` pulse.
- Read 3 bytes: `tx_data`=0x00112233, `tx_bytes`=3; START, 0x85, read bytes ACK, ACK, NACK, STOP → bus carries 0x11, 0x22, 0x33; SDA released after NACK; `done` pulses.
- Read 5 bytes with `tx_bytes`=2, `tx_data`=0x0000BEEF → bytes 0xBE, 0xEF, 0xFF, 0xFF, 0xFF.
- Address mismatch: START, 0x90, 0x55, STOP → SDA never driven low; `busy` stays 0; no `rx_byte_valid`; no `done`.
- Repeated START: write 0x84, 0x01, then START, 0x85, read 1 byte NACK, STOP (`tx_bytes`=1, `tx_data`=0x7E) → `rx_data`=0x01; 0x7E returned; `busy` continuously high; exactly one `done`.
- Aborts:
  - `rst` asserted during a read bit that drives 0 → SDA becomes `z` next clk; a following clean write transaction behaves as in scenario 1.
  - STOP after 4 bits of a data byte → no `rx_byte_valid`; IDLE.

Source files
------------

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Purpose  : 7-bit-address I2C target with oversampled SCL/SDA, address
//            match/ACK, write receive shifting and up-to-4-byte read payload.
// Revision : 1.0
// ============================================================================
module i2c_target #(
    parameter logic [6:0] ADDRESS = 7'h42,
    parameter int         HOLD    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic [31:0] tx_data,
    input  logic [2:0]  tx_bytes,
    output logic [31:0] rx_data,
    output logic        rx_byte_valid,
    output logic [2:0]  rx_count,
    output logic        rw,
    output logic        busy,
    output logic        done
);
    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ADDR      = 3'd1;
    localparam logic [2:0] c_ADDR_ACK  = 3'd2;
    localparam logic [2:0] c_WRITE     = 3'd3;
    localparam logic [2:0] c_WRITE_ACK = 3'd4;
    localparam logic [2:0] c_READ      = 3'd5;
    localparam logic [2:0] c_READ_ACK  = 3'd6;
    localparam logic [2:0] c_IGNORE    = 3'd7;
    localparam logic [3:0] c_HOLD      = 4'(HOLD);

    logic [2:0]  r_scl_sync, r_sda_sync;
    logic        w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [2:0]  r_state, w_state_nx;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic [7:0]  w_rx_byte;
    logic        w_last_bit, w_addr_match;
    logic [3:0]  r_hold_cnt;
    logic        w_fire;
    logic        r_sda_low, w_drive_low;
    logic [31:0] r_tx_data;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_idx, w_tx_first;
    logic        r_new_write;

    // idx counts remaining payload bytes; idx 4 is the most significant byte
    function automatic logic [7:0] f_tx_byte(input logic [31:0] data, input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            3'd1:    v = data[7:0];
            3'd2:    v = data[15:8];
            3'd3:    v = data[23:16];
            3'd4:    v = data[31:24];
            default: v = 8'hFF;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] f_dec(input logic [2:0] idx);
        return (idx == 3'd0) ? 3'd0 : idx - 3'd1;
    endfunction

    assign sda = r_sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], scl};
            r_sda_sync <= {r_sda_sync[1:0], sda};
        end
    end

    assign w_scl        = r_scl_sync[1];
    assign w_sda        = r_sda_sync[1];
    assign w_scl_rise   = w_scl & ~r_scl_sync[2];
    assign w_scl_fall   = ~w_scl & r_scl_sync[2];
    assign w_start      = w_scl & r_sda_sync[2] & ~w_sda;
    assign w_stop       = w_scl & ~r_sda_sync[2] & w_sda;
    assign w_rx_byte    = {r_shift, w_sda};
    assign w_last_bit   = (r_bit_cnt == 3'd7);
    assign w_addr_match = (w_rx_byte[7:1] == ADDRESS);
    assign w_tx_first   = (tx_bytes > 3'd4) ? 3'd4 : tx_bytes;
    assign w_fire       = (r_hold_cnt == 4'd1);

    // SDA updates only when this countdown, armed by an SCL fall, expires
    always_ff @(posedge clk) begin
        if (rst)                  r_hold_cnt <= 4'd0;
        else if (w_scl_fall)      r_hold_cnt <= c_HOLD;
        else if (r_hold_cnt != 0) r_hold_cnt <= r_hold_cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_start) begin
            w_state_nx = c_ADDR;
        end else if (w_stop) begin
            w_state_nx = c_IDLE;
        end else if (w_scl_rise) begin
            case (r_state)
                c_ADDR:      if (w_last_bit) w_state_nx = w_addr_match ? c_ADDR_ACK : c_IGNORE;
                c_ADDR_ACK:  w_state_nx = rw ? c_READ : c_WRITE;
                c_WRITE:     if (w_last_bit) w_state_nx = c_WRITE_ACK;
                c_WRITE_ACK: w_state_nx = c_WRITE;
                c_READ:      if (w_last_bit) w_state_nx = c_READ_ACK;
                c_READ_ACK:  w_state_nx = w_sda ? c_IGNORE : c_READ;
                default:     w_state_nx = r_state;
            endcase
        end
    end

    always_comb begin
        w_drive_low = 1'b0;
        case (r_state)
            c_ADDR_ACK, c_WRITE_ACK: w_drive_low = 1'b1;
            c_READ:                  w_drive_low = ~r_tx_shift[7];
            default:                 w_drive_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt     <= 3'd0;
            r_shift       <= 7'd0;
            r_sda_low     <= 1'b0;
            r_tx_data     <= 32'd0;
            r_tx_shift    <= 8'hFF;
            r_tx_idx      <= 3'd0;
            r_new_write   <= 1'b0;
            rx_data       <= 32'd0;
            rx_byte_valid <= 1'b0;
            rx_count      <= 3'd0;
            rw            <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            rx_byte_valid <= 1'b0;
            done          <= 1'b0;
            if (w_fire) begin
                r_sda_low <= w_drive_low;
                if (r_state == c_ADDR_ACK) busy <= 1'b1;
            end
            if (w_start) begin
                r_bit_cnt <= 3'd0;
                r_sda_low <= 1'b0;
            end else if (w_stop) begin
                r_sda_low <= 1'b0;
                busy      <= 1'b0;
                done      <= busy;
            end else if (w_scl_rise) begin
                case (r_state)
                    c_ADDR: begin
                        r_shift   <= w_rx_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            if (w_addr_match) rw   <= w_sda;
                            else              busy <= 1'b0;
                        end
                    end
                    c_ADDR_ACK: begin
                        r_bit_cnt <= 3'd0;
                        if (rw) begin
                            r_tx_data  <= tx_data;
                            r_tx_shift <= f_tx_byte(tx_data, w_tx_first);
                            r_tx_idx   <= f_dec(w_tx_first);
                        end else begin
                            r_new_write <= 1'b1;
                        end
                    end
                    c_WRITE: begin
                        r_shift   <= w_rx_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            rx_data       <= {rx_data[23:0], w_rx_byte};
                            rx_byte_valid <= 1'b1;
                            rx_count      <= r_new_write ? 3'd1 :
                                             (rx_count == 3'd7) ? 3'd7 : rx_count + 3'd1;
                            r_new_write   <= 1'b0;
                        end
                    end
                    c_READ: begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                    end
                    c_READ_ACK: begin
                        if (!w_sda) begin
                            r_tx_shift <= f_tx_byte(r_tx_data, r_tx_idx);
                            r_tx_idx   <= f_dec(r_tx_idx);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target
// Purpose  : bit-banged I2C master driving i2c_target against a transaction-
//            level reference model, directed scenarios plus random transfers.
// Revision : 1.0
// ============================================================================
module tb_i2c_target;
    localparam int c_Q = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl = 1'b1;
    logic        m_drive_low = 1'b0;
    logic [31:0] tx_data = 32'd0;
    logic [2:0]  tx_bytes = 3'd0;
    wire         sda;
    logic [31:0] rx_data;
    logic        rx_byte_valid;
    logic [2:0]  rx_count;
    logic        rw, busy, done;

    assign sda = m_drive_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_target #(.ADDRESS(7'h42), .HOLD(4)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .tx_data(tx_data), .tx_bytes(tx_bytes),
        .rx_data(rx_data), .rx_byte_valid(rx_byte_valid), .rx_count(rx_count),
        .rw(rw), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid = 0, n_done = 0, n_dut_low = 0, n_busy_fall = 0;
    logic r_busy_q = 1'b0;

    always @(negedge clk) begin
        if (rx_byte_valid) n_valid <= n_valid + 1;
        if (done) n_done <= n_done + 1;
        if (sda == 1'b0 && !m_drive_low) n_dut_low <= n_dut_low + 1;
        if (r_busy_q && !busy) n_busy_fall <= n_busy_fall + 1;
        r_busy_q <= busy;
    end

    // reference model state
    logic [31:0] m_rx_data = 32'd0;
    int          m_rx_count = 0;
    logic        m_rw = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_read(input logic [31:0] d, input int n, input int k);
        if (k < n) return 8'((d >> (8 * (n - 1 - k))) & 32'hFF);
        return 8'hFF;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(2);
        m_rx_data = 32'd0;
        m_rx_count = 0;
        m_rw = 1'b0;
    endtask

    task automatic bus_bit(input logic b, output logic rb);
        clks(c_Q); m_drive_low = ~b;
        clks(c_Q); scl = 1'b1;
        clks(c_Q); rb = sda;
        clks(c_Q); scl = 1'b0;
    endtask

    task automatic bus_start();
        m_drive_low = 1'b0;
        clks(c_Q); scl = 1'b1;
        clks(c_Q); m_drive_low = 1'b1;
        clks(c_Q); scl = 1'b0;
    endtask

    task automatic bus_stop();
        clks(c_Q); m_drive_low = 1'b1;
        clks(c_Q); scl = 1'b1;
        clks(c_Q); m_drive_low = 1'b0;
        clks(2 * c_Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic rb;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], rb);
        bus_bit(1'b1, rb);
        ack = ~rb;
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] b);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, rb);
            b[i] = rb;
        end
        bus_bit(~send_ack, rb);
    endtask

    task automatic run_xfer(input logic [6:0] addr, input logic rnw, input int n,
                            input logic [63:0] wbytes, input logic [31:0] txd, input logic [2:0] txb);
        logic       ack, hit;
        logic [7:0] rb;
        int         v0, d0, l0;
        hit = (addr == 7'h42);
        v0 = n_valid; d0 = n_done; l0 = n_dut_low;
        tx_data = txd; tx_bytes = txb;
        bus_start();
        write_byte({addr, rnw}, ack);
        check_val("addr_ack", 32'(ack), 32'(hit));
        if (!rnw) begin
            for (int i = 0; i < n; i++) begin
                write_byte(wbytes[8*i +: 8], ack);
                check_val("wr_ack", 32'(ack), 32'(hit));
                if (hit) m_rx_data = (m_rx_data << 8) | 32'(wbytes[8*i +: 8]);
            end
            if (hit) m_rx_count = (n > 7) ? 7 : n;
        end else begin
            for (int i = 0; i < n; i++) begin
                read_byte(i != n - 1, rb);
                check_val("rd_byte", 32'(rb), hit ? 32'(exp_read(txd, 32'(txb), i)) : 32'hFF);
            end
            clks(c_Q);
            check_val("rd_release", 32'(sda), 32'd1);
        end
        if (hit) m_rw = rnw;
        bus_stop();
        check_val("valid_pulses", 32'(n_valid - v0), (hit && !rnw) ? 32'(n) : 32'd0);
        check_val("done_pulses", 32'(n_done - d0), 32'(hit));
        check_val("busy_after", 32'(busy), 32'd0);
        check_val("rx_data", rx_data, m_rx_data);
        check_val("rx_count", 32'(rx_count), 32'(m_rx_count));
        check_val("rw", 32'(rw), 32'(m_rw));
        if (!hit) check_val("nomatch_sda", 32'(n_dut_low - l0), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         v0, d0, b0;
        logic [6:0] addr;
        logic       rnw;
        int         n;

        do_reset();
        check_val("rst_rx_data", rx_data, 32'd0);
        check_val("rst_rx_count", 32'(rx_count), 32'd0);
        check_val("rst_rw", 32'(rw), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_valid", 32'(rx_byte_valid), 32'd0);
        check_val("rst_sda", 32'(sda), 32'd1);

        run_xfer(7'h42, 1'b0, 2, 64'h3CA5, 32'd0, 3'd0);
        check_val("w2_rx_data_const", rx_data, 32'h0000A53C);
        run_xfer(7'h42, 1'b1, 3, 64'd0, 32'h00112233, 3'd3);
        run_xfer(7'h42, 1'b1, 5, 64'd0, 32'h0000BEEF, 3'd2);
        run_xfer(7'h48, 1'b0, 1, 64'h55, 32'd0, 3'd0);

        // repeated START from a write into a read
        do_reset();
        v0 = n_valid; d0 = n_done; b0 = n_busy_fall;
        bus_start();
        write_byte(8'h84, ack); check_val("rs_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h01, ack); check_val("rs_data_ack", 32'(ack), 32'd1);
        tx_data = 32'h0000007E; tx_bytes = 3'd1;
        bus_start();
        write_byte(8'h85, ack); check_val("rs_raddr_ack", 32'(ack), 32'd1);
        read_byte(1'b0, rb);    check_val("rs_rd_byte", 32'(rb), 32'h7E);
        bus_stop();
        m_rx_data = 32'h01; m_rx_count = 1; m_rw = 1'b1;
        check_val("rs_rx_data", rx_data, 32'h00000001);
        check_val("rs_valid", 32'(n_valid - v0), 32'd1);
        check_val("rs_done", 32'(n_done - d0), 32'd1);
        check_val("rs_busy_falls", 32'(n_busy_fall - b0), 32'd1);
        check_val("rs_rw", 32'(rw), 32'd1);

        // reset while the target drives a 0 data bit
        do_reset();
        tx_data = 32'd0; tx_bytes = 3'd1;
        bus_start();
        write_byte(8'h85, ack); check_val("ab_addr_ack", 32'(ack), 32'd1);
        clks(c_Q);
        check_val("ab_drive_low", 32'(sda), 32'd0);
        rst = 1'b1;
        clks(1);
        check_val("ab_rst_release", 32'(sda), 32'd1);
        clks(2);
        rst = 1'b0;
        m_rx_data = 32'd0; m_rx_count = 0; m_rw = 1'b0;
        bus_stop();
        run_xfer(7'h42, 1'b0, 2, 64'h3CA5, 32'd0, 3'd0);

        // STOP in the middle of a data byte
        v0 = n_valid; d0 = n_done;
        bus_start();
        write_byte(8'h84, ack); check_val("sp_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) bus_bit(i[0] ? 1'b0 : 1'b1, rb);
        bus_stop();
        check_val("sp_valid", 32'(n_valid - v0), 32'd0);
        check_val("sp_done", 32'(n_done - d0), 32'd1);
        check_val("sp_busy", 32'(busy), 32'd0);
        check_val("sp_rx_data", rx_data, m_rx_data);
        check_val("sp_rx_count", 32'(rx_count), 32'(m_rx_count));

        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 3) != 0) begin
                addr = 7'h42;
            end else begin
                addr = 7'($urandom_range(0, 127));
                if (addr == 7'h42) addr = 7'h43;
            end
            rnw = 1'($urandom_range(0, 1));
            n = rnw ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 8));
            run_xfer(addr, rnw, n, {$urandom, $urandom}, $urandom, 3'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
